// File: rtl/bidir_sipo_rx.sv
// bidir_sipo_rx: serial-in parallel-out receiver with per-word shift direction
//
// Parameters:
//   WIDTH       parallel word width (2..32)
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   sin         serial data bit, sampled when sin_en=1
//   sin_en      bit strobe
//   dir         1 = MSB-first (left shift), 0 = LSB-first (right shift)
//   clr         synchronous clear of the partial word and overrun
//   q           assembled parallel word
//   q_valid     q holds an unconsumed word
//   q_ready     consumer accepts q on an edge where q_valid=1
//   busy        a partial word is in progress
//   overrun     sticky flag: a completed word was dropped
//   parity_err  (BIDIR_SIPO_RX_PARITY_EN only) XOR of data bits and parity bit
//
// Build option:
//   BIDIR_SIPO_RX_PARITY_EN  append an even-parity bit after every WIDTH data bits
module bidir_sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             dir,
    input  logic             clr,
    input  logic             q_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             overrun
`ifdef BIDIR_SIPO_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH);

`ifdef BIDIR_SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic             dir_l;
    logic             dsel;
    logic             last;
    logic             done;
    logic             accept;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] word;
`ifdef BIDIR_SIPO_RX_PARITY_EN
    logic             perr;
`endif

    assign busy = state != IDLE;

    always_comb begin
        // the first bit of a word uses the live dir; later bits use the latched copy
        dsel   = (state == IDLE) ? dir : dir_l;
        nxt    = dsel ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
        last   = cnt == CW'(WIDTH - 1);
        accept = !q_valid || q_ready;
`ifdef BIDIR_SIPO_RX_PARITY_EN
        done   = !clr && sin_en && (state == PAR);
        word   = sr;
        perr   = ^{sr, sin};
`else
        done   = !clr && sin_en && last;
        word   = nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            dir_l      <= 1'b0;
            q          <= '0;
            q_valid    <= 1'b0;
            overrun    <= 1'b0;
`ifdef BIDIR_SIPO_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (q_valid && q_ready)
                q_valid <= 1'b0;
            // a completing word either lands in q or is dropped and flagged
            if (done) begin
                if (accept) begin
                    q       <= word;
                    q_valid <= 1'b1;
`ifdef BIDIR_SIPO_RX_PARITY_EN
                    parity_err <= perr;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (clr) begin
                state   <= IDLE;
                cnt     <= '0;
                sr      <= '0;
                overrun <= 1'b0;
            end else if (sin_en) begin
`ifdef BIDIR_SIPO_RX_PARITY_EN
                if (state == PAR) begin
                    sr    <= '0;
                    state <= IDLE;
                end else
`endif
                begin
                    if (state == IDLE)
                        dir_l <= dir;
                    if (last) begin
                        cnt <= '0;
`ifdef BIDIR_SIPO_RX_PARITY_EN
                        sr    <= nxt;
                        state <= PAR;
`else
                        sr    <= '0;
                        state <= IDLE;
`endif
                    end else begin
                        sr    <= nxt;
                        cnt   <= cnt + CW'(1);
                        state <= SHIFT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bidir_sipo_rx.sv
// tb_bidir_sipo_rx: directed vector bench for bidir_sipo_rx at WIDTH=4
module tb_bidir_sipo_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       dir = 1'b0;
    logic       clr = 1'b0;
    logic       q_ready = 1'b0;
    logic [3:0] q;
    logic       q_valid;
    logic       busy;
    logic       overrun;
`ifdef BIDIR_SIPO_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bidir_sipo_rx #(.WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sin(sin),
        .sin_en(sin_en),
        .dir(dir),
        .clr(clr),
        .q_ready(q_ready),
        .q(q),
        .q_valid(q_valid),
        .busy(busy),
        .overrun(overrun)
`ifdef BIDIR_SIPO_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    typedef struct {
        logic       d;
        logic [3:0] bits;
        logic       rdy;
        logic       cons;
        logic       clr_after;
        logic [3:0] eq;
        logic       ev;
        logic       eo;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sin    = b;
        sin_en = 1'b1;
        tick();
        sin_en = 1'b0;
    endtask

    // bits[3] is sent first; rdy is driven only on the completing edge
    task automatic send_word(input logic [3:0] bits, input logic d, input logic rdy, input logic pbit);
        dir = d;
        for (int i = 3; i >= 0; i--) begin
            sin    = bits[i];
            sin_en = 1'b1;
`ifdef BIDIR_SIPO_RX_PARITY_EN
            q_ready = 1'b0;
`else
            q_ready = (i == 0) ? rdy : 1'b0;
`endif
            tick();
        end
`ifdef BIDIR_SIPO_RX_PARITY_EN
        sin     = pbit;
        sin_en  = 1'b1;
        q_ready = rdy;
        tick();
`else
        if (pbit === 1'bx) $display("unexpected parity argument");
`endif
        sin_en  = 1'b0;
        q_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 4'b1011, 1'b0, 1'b1, 1'b0, 4'b1101, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'hA,    1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, 4'hA,    1'b1, 1'b1};
        tbl[4] = '{1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 4'h5,    1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0};

        tick();
        tick();
        chk("rst_q", q, 0);
        chk("rst_valid", q_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
`ifdef BIDIR_SIPO_RX_PARITY_EN
        chk("rst_perr", parity_err, 0);
`endif
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].bits, tbl[i].d, tbl[i].rdy, ^tbl[i].bits);
            chk($sformatf("v%0d_q", i), q, tbl[i].eq);
            chk($sformatf("v%0d_valid", i), q_valid, tbl[i].ev);
            chk($sformatf("v%0d_overrun", i), overrun, tbl[i].eo);
            chk($sformatf("v%0d_busy", i), busy, 0);
`ifdef BIDIR_SIPO_RX_PARITY_EN
            chk($sformatf("v%0d_perr", i), parity_err, 0);
`endif
            if (tbl[i].clr_after) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                chk($sformatf("v%0d_clr_overrun", i), overrun, 0);
                chk($sformatf("v%0d_clr_valid", i), q_valid, 1);
                chk($sformatf("v%0d_clr_q", i), q, tbl[i].eq);
            end
            if (tbl[i].cons) begin
                q_ready = 1'b1;
                tick();
                q_ready = 1'b0;
                chk($sformatf("v%0d_cons_valid", i), q_valid, 0);
                chk($sformatf("v%0d_cons_q", i), q, tbl[i].eq);
            end
        end

        // gaps in sin_en and a mid-word dir change must not disturb the word
        dir = 1'b1;
        send_bit(1'b1);
        tick();
        tick();
        chk("gap_busy", busy, 1);
        dir = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        chk("gap_busy3", busy, 1);
        send_bit(1'b1);
`ifdef BIDIR_SIPO_RX_PARITY_EN
        chk("par_busy", busy, 1);
        send_bit(1'b1);
`endif
        chk("gap_q", q, 4'b1011);
        chk("gap_valid", q_valid, 1);
        chk("gap_busy_end", busy, 0);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;

        // clr beats sin_en and discards the partial word
        dir = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        clr    = 1'b1;
        sin_en = 1'b1;
        sin    = 1'b0;
        tick();
        clr    = 1'b0;
        sin_en = 1'b0;
        chk("clr_busy", busy, 0);
        send_word(4'b0011, 1'b1, 1'b0, 1'b0);
        chk("clr_next_q", q, 4'b0011);
        chk("clr_next_valid", q_valid, 1);
        clr     = 1'b1;
        q_ready = 1'b1;
        tick();
        clr     = 1'b0;
        q_ready = 1'b0;
        chk("clr_hs_valid", q_valid, 0);
        chk("clr_hs_q", q, 4'b0011);

        // asynchronous reset mid-word
        send_word(4'b1100, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        dir = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", q, 0);
        chk("arst_valid", q_valid, 0);
        chk("arst_busy", busy, 0);
        #1 rst_n = 1'b1;
        send_word(4'b0110, 1'b1, 1'b0, 1'b0);
        chk("post_rst_q", q, 4'b0110);
        chk("post_rst_valid", q_valid, 1);

        // back-to-back words with handshakes on the completion edges
        send_word(4'b1100, 1'b1, 1'b1, 1'b0);
        chk("b2b1_q", q, 4'b1100);
        send_word(4'b0011, 1'b1, 1'b1, 1'b0);
        chk("b2b2_q", q, 4'b0011);
        chk("b2b2_valid", q_valid, 1);
        chk("b2b2_overrun", overrun, 0);

`ifdef BIDIR_SIPO_RX_PARITY_EN
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        send_word(4'b1011, 1'b1, 1'b0, 1'b0);
        chk("perr_q", q, 4'b1011);
        chk("perr_flag", parity_err, 1);
        chk("perr_valid", q_valid, 1);
        send_word(4'b0101, 1'b1, 1'b0, 1'b0);
        chk("perr_drop_q", q, 4'b1011);
        chk("perr_drop_flag", parity_err, 1);
        chk("perr_drop_overrun", overrun, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
